// File: rtl/scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit
//
// Register scoreboard for the RV64I pipeline. Replaces fixed E/M/W compare
// based hazard detection so variable-latency units (load, mul/div) can retire
// out of order on NUM_WB independent write-back ports.
//
// A bitmap records every architectural register that has an issued but not
// yet completed writer. Decode is stalled on RAW, WAW or capacity hazards,
// and a source operand being written back in the current cycle is bypassed
// from that write-back port instead of stalling.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   issue_valid  decode stage holds a valid instruction
//   flush        squash the decode-stage instruction this cycle
//   rs1_use/rs1  source 1 read enable / index
//   rs2_use/rs2  source 2 read enable / index
//   rd_use/rd    destination write enable / index
//   wb_valid     per-port completion strobe
//   wb_rd        per-port completing register, port k = [k*REG_AW +: REG_AW]
//   stall        hold decode/fetch, issue nothing
//   issue_fire   instruction leaves decode this cycle
//   rs1_fwd_sel  0 = register file, k+1 = bypass from write-back port k
//   rs2_fwd_sel  as rs1_fwd_sel
//   busy_vec     registered pending-write bitmap (bit 0 always 0)
//   outstanding  registered count of set busy bits
//   err          sticky protocol-error flag
// -----------------------------------------------------------------------------
module scoreboard_hazard_unit #(
  parameter  int REG_AW   = 5,
  parameter  int NUM_WB   = 2,
  parameter  int MAX_OUT  = 8,
  localparam int NUM_REGS = 1 << REG_AW,
  localparam int SEL_W    = $clog2(NUM_WB + 1),
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     flush,
  input  logic                     rs1_use,
  input  logic [REG_AW-1:0]        rs1,
  input  logic                     rs2_use,
  input  logic [REG_AW-1:0]        rs2,
  input  logic                     rd_use,
  input  logic [REG_AW-1:0]        rd,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*REG_AW-1:0] wb_rd,
  output logic                     stall,
  output logic                     issue_fire,
  output logic [SEL_W-1:0]         rs1_fwd_sel,
  output logic [SEL_W-1:0]         rs2_fwd_sel,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic int unsigned popcount(input logic [NUM_REGS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Lowest-numbered write-back port completing rs wins the bypass.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic                     use_i,
    input logic [REG_AW-1:0]        rs,
    input logic [NUM_WB-1:0]        vld,
    input logic [NUM_WB*REG_AW-1:0] rds
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (use_i && (rs != '0)) begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (vld[k] && (rds[k*REG_AW +: REG_AW] == rs)) sel = SEL_W'(k + 1);
      end
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] set_v;
  logic                err_evt;
  logic                rs1_haz, rs2_haz, waw_haz, cap_haz;
  int                  remain;

  // ---------------------------------------------------------------------------
  // Completion decode: registers retiring this cycle (x0 never tracked)
  // ---------------------------------------------------------------------------
  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_rd[k*REG_AW +: REG_AW] != '0)) begin
        clr[wb_rd[k*REG_AW +: REG_AW]] = 1'b1;
      end
    end
  end

  // A register completing this cycle no longer blocks a reader or writer.
  assign eff_busy = busy_q & ~clr;

  // Protocol checks: completion of an idle register, or two ports retiring
  // the same register in one cycle.
  always_comb begin
    err_evt = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_rd[k*REG_AW +: REG_AW] != '0)) begin
        if (!busy_q[wb_rd[k*REG_AW +: REG_AW]]) err_evt = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (wb_valid[j] &&
              (wb_rd[j*REG_AW +: REG_AW] == wb_rd[k*REG_AW +: REG_AW])) begin
            err_evt = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard evaluation and issue gating
  // ---------------------------------------------------------------------------
  always_comb begin
    // Writers that will still be in flight after this cycle's completions.
    // Only retirements of genuinely busy registers free a slot, so a stray
    // completion cannot push the in-flight count past MAX_OUT.
    remain  = int'(outstanding_q) - int'(popcount(busy_q & clr));

    rs1_haz = rs1_use && (rs1 != '0) && eff_busy[rs1];
    rs2_haz = rs2_use && (rs2 != '0) && eff_busy[rs2];
    waw_haz = rd_use  && (rd  != '0) && eff_busy[rd];
    cap_haz = rd_use  && (rd  != '0) && (remain == MAX_OUT);

    stall      = issue_valid && !flush &&
                 (rs1_haz || rs2_haz || waw_haz || cap_haz);
    issue_fire = issue_valid && !flush && !stall;
  end

  assign rs1_fwd_sel = fwd_pick(rs1_use, rs1, wb_valid, wb_rd);
  assign rs2_fwd_sel = fwd_pick(rs2_use, rs2, wb_valid, wb_rd);

  // ---------------------------------------------------------------------------
  // Next-state: clear retiring registers, then set the newly issued rd so a
  // same-cycle retire/reissue of one register leaves it busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    set_v = '0;
    if (issue_fire && rd_use && (rd != '0)) set_v[rd] = 1'b1;

    busy_d        = (busy_q & ~clr) | set_v;
    busy_d[0]     = 1'b0;
    outstanding_d = CNT_W'(popcount(busy_d));
    err_d         = err_q | err_evt;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule
